// File: rtl/cc_victim_sel.sv
// N-way replacement-victim selector: invalid-way priority, lock mask, and a
// run-time choice of LFSR-random, round-robin or tree-PLRU start point.
module cc_victim_sel #(
    parameter int          NUM_WAYS = 4,
    parameter logic [15:0] SEED     = 16'h0001,
    localparam int         WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode_i,
    input  logic                update_i,
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic [NUM_WAYS-1:0] lock_i,
    input  logic                touch_i,
    input  logic [WAY_W-1:0]    touch_way_i,
    output logic [WAY_W-1:0]    victim_o,
    output logic                victim_none_o
);

    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // 1-based heap: node 1 is the root, children of n are 2n and 2n+1.
    typedef logic [NUM_WAYS-1:1] tree_t;

    function automatic tree_t f_touch(input tree_t t, input logic [WAY_W-1:0] way);
        tree_t            r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] path;
        logic             b;
        r    = t;
        node = WAY_W'(1);
        path = way;
        for (int l = 0; l < WAY_W; l++) begin
            b       = path[WAY_W-1];
            r[node] = ~b;
            node    = WAY_W'({node, b});
            path    = path << 1;
        end
        return r;
    endfunction

    logic [15:0]         r_lfsr;
    logic [WAY_W-1:0]    r_rr_ptr;
    tree_t               r_tree;
    logic [WAY_W-1:0]    r_victim;
    logic                r_none;

    logic [NUM_WAYS-1:0] w_elig;
    logic                w_any_elig;
    logic [WAY_W-1:0]    w_plru_way;
    logic [WAY_W-1:0]    w_start;
    logic [WAY_W-1:0]    w_scan;
    logic [WAY_W-1:0]    w_victim;
    logic [15:0]         w_lfsr_next;
    tree_t               w_tree_touched;

    assign w_elig      = ~lock_i;
    assign w_any_elig  = |w_elig;
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_comb begin
        logic [WAY_W-1:0] node;
        logic             b;
        node       = WAY_W'(1);
        w_plru_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b          = r_tree[node];
            w_plru_way = WAY_W'({w_plru_way, b});
            node       = WAY_W'({node, b});
        end
    end

    always_comb begin
        case (mode_i)
            2'd1:    w_start = r_rr_ptr;
            2'd2:    w_start = w_plru_way;
            default: w_start = r_lfsr[WAY_W-1:0];
        endcase
    end

    // Scans run high-to-low so the last hit written is the lowest offset.
    always_comb begin
        logic [WAY_W-1:0] idx;
        w_scan = '0;
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            idx = w_start + WAY_W'(k);
            if (w_elig[idx]) w_scan = idx;
        end
        w_victim = w_scan;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            idx = WAY_W'(i);
            if (w_elig[idx] && !valid_i[idx]) w_victim = idx;
        end
    end

    assign w_tree_touched = touch_i ? f_touch(r_tree, touch_way_i) : r_tree;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr   <= LFSR_INIT;
            r_rr_ptr <= '0;
            r_tree   <= '0;
            r_victim <= '0;
            r_none   <= 1'b0;
        end else begin
            r_tree <= w_tree_touched;
            if (update_i) begin
                if (w_any_elig) begin
                    r_victim <= w_victim;
                    r_none   <= 1'b0;
                    r_lfsr   <= w_lfsr_next;
                    r_rr_ptr <= w_victim + WAY_W'(1);
                    // The victim's touch is applied last so it owns shared nodes.
                    r_tree   <= f_touch(w_tree_touched, w_victim);
                end else begin
                    r_none <= 1'b1;
                end
            end
        end
    end

    assign victim_o      = r_victim;
    assign victim_none_o = r_none;

    a_touch_way_range: assert property (@(posedge clk) disable iff (!rst_n)
        touch_i |-> (int'(touch_way_i) < NUM_WAYS));

endmodule
